// File: rtl/jet_pkg.sv
`default_nettype none
// =============================================================================
//  Module   : jet_pkg
//  Purpose  : Shared types and keycodes for the jet / missile blocks.
//  Revision : 1.0 - initial release
// =============================================================================
package jet_pkg;

   // Heading of the jet and of a missile in flight
   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   // Missile launcher sequencing
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLYING   = 2'd1,
      COOLDOWN = 2'd2
   } launcher_state_t;

   // USB HID keyboard usage codes
   localparam logic [7:0] KEY_W    = 8'h1A;
   localparam logic [7:0] KEY_A    = 8'h04;
   localparam logic [7:0] KEY_S    = 8'h16;
   localparam logic [7:0] KEY_D    = 8'h07;
   localparam logic [7:0] KEY_FIRE = 8'h2C;

   // Inclusive window test on 11-bit signed screen coordinates
   function automatic logic in_window(input logic signed [10:0] v,
                                      input logic signed [10:0] lo,
                                      input logic signed [10:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// =============================================================================
//  Module   : frame_tick_gen
//  Purpose  : Brings the vsync-rate frame strobe into the Clk domain and
//             emits a single-cycle pulse on each rising edge.
//  Revision : 1.0 - initial release
// =============================================================================
module frame_tick_gen (
   input  logic Clk,
   input  logic Reset,       // asynchronous, active-low
   input  logic frame_clk,
   output logic frame_tick
);

   logic sync_1;
   logic sync_2;
   logic sync_prev;

   // Two-flop synchronizer followed by an edge-history flop
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sync_1    <= 1'b0;
         sync_2    <= 1'b0;
         sync_prev <= 1'b0;
      end else begin
         sync_1    <= frame_clk;
         sync_2    <= sync_1;
         sync_prev <= sync_2;
      end
   end

   assign frame_tick = sync_2 & ~sync_prev;

endmodule
`default_nettype wire

// File: rtl/missile_launcher.sv
`default_nettype none
// =============================================================================
//  Module   : missile_launcher
//  Purpose  : Launches a single missile from the jet nose on a fire-key press,
//             moves it once per frame along its launch heading, retires it at
//             the screen edge and then holds off relaunch for a cooldown.
//  Options  : MISSILE_WRAP_EN - missile wraps at the edges and instead expires
//             after LIFETIME_FRAMES flight ticks.
//  Revision : 1.0 - initial release
// =============================================================================
module missile_launcher
   import jet_pkg::*;
#(
   parameter int X_MIN           = 5,
   parameter int X_MAX           = 639,
   parameter int Y_MIN           = 6,
   parameter int Y_MAX           = 474,
   parameter int MISSILE_STEP    = 8,
   parameter int MISSILE_SIZE    = 4,
   parameter int COOLDOWN_FRAMES = 15
`ifdef MISSILE_WRAP_EN
   ,
   parameter int LIFETIME_FRAMES = 60
`endif
) (
   input  logic       Clk,
   input  logic       Reset,          // asynchronous, active-low
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   input  logic [9:0] JetX,
   input  logic [9:0] JetY,
   input  logic [9:0] JetS,
   output logic [9:0] MissileX,
   output logic [9:0] MissileY,
   output logic [9:0] MissileS,
   output logic       MissileActive
);

   localparam logic signed [10:0] XLO  = 11'(X_MIN);
   localparam logic signed [10:0] XHI  = 11'(X_MAX);
   localparam logic signed [10:0] YLO  = 11'(Y_MIN);
   localparam logic signed [10:0] YHI  = 11'(Y_MAX);
   localparam logic signed [10:0] STEP = 11'(MISSILE_STEP);
   localparam int CD_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

   logic            frame_tick;
   launcher_state_t state, state_nxt;
   dir_t            dir, dir_nxt;
   dir_t            fly_dir, fly_dir_nxt;
   logic            fire_prev, fire_prev_nxt;
   logic [CD_W-1:0] cd, cd_nxt;
   logic [9:0]      x_nxt, y_nxt;
   logic            active_nxt;

   frame_tick_gen u_tick (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_clk  (frame_clk),
      .frame_tick (frame_tick)
   );

   assign MissileS = 10'(MISSILE_SIZE);

   // Spawn point at the jet nose for the current heading
   logic signed [10:0] jx, jy, js, spawn_x, spawn_y;
   logic               spawn_ok, fire_edge;
   assign jx       = $signed({1'b0, JetX});
   assign jy       = $signed({1'b0, JetY});
   assign js       = $signed({1'b0, JetS});
   assign spawn_x  = (dir == LEFT) ? jx - js : (dir == RIGHT) ? jx + js : jx;
   assign spawn_y  = (dir == UP)   ? jy - js : (dir == DOWN)  ? jy + js : jy;
   assign spawn_ok = in_window(spawn_x, XLO, XHI) && in_window(spawn_y, YLO, YHI);
   assign fire_edge = (keycode == KEY_FIRE) && !fire_prev;

   // Candidate next position along the latched flight axis
   logic signed [10:0] cur_x, cur_y, step_x, step_y;
   logic               step_ok;
   assign cur_x   = $signed({1'b0, MissileX});
   assign cur_y   = $signed({1'b0, MissileY});
   assign step_x  = (fly_dir == LEFT) ? cur_x - STEP : (fly_dir == RIGHT) ? cur_x + STEP : cur_x;
   assign step_y  = (fly_dir == UP)   ? cur_y - STEP : (fly_dir == DOWN)  ? cur_y + STEP : cur_y;
   assign step_ok = in_window(step_x, XLO, XHI) && in_window(step_y, YLO, YHI);

`ifdef MISSILE_WRAP_EN
   localparam logic signed [10:0] XSPAN = 11'(X_MAX - X_MIN + 1);
   localparam logic signed [10:0] YSPAN = 11'(Y_MAX - Y_MIN + 1);
   localparam int LT_W = $clog2(LIFETIME_FRAMES + 1);

   logic [LT_W-1:0]    life, life_nxt, life_inc;
   logic signed [10:0] wrap_x, wrap_y;
   assign life_inc = life + LT_W'(1);
   assign wrap_x = (step_x > XHI) ? step_x - XSPAN : (step_x < XLO) ? step_x + XSPAN : step_x;
   assign wrap_y = (step_y > YHI) ? step_y - YSPAN : (step_y < YLO) ? step_y + YSPAN : step_y;
`endif

   // State and datapath registers; everything advances through the *_nxt terms
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state         <= IDLE;
         dir           <= UP;
         fly_dir       <= UP;
         fire_prev     <= 1'b0;
         cd            <= '0;
         MissileX      <= '0;
         MissileY      <= '0;
         MissileActive <= 1'b0;
`ifdef MISSILE_WRAP_EN
         life          <= '0;
`endif
      end else begin
         state         <= state_nxt;
         dir           <= dir_nxt;
         fly_dir       <= fly_dir_nxt;
         fire_prev     <= fire_prev_nxt;
         cd            <= cd_nxt;
         MissileX      <= x_nxt;
         MissileY      <= y_nxt;
         MissileActive <= active_nxt;
`ifdef MISSILE_WRAP_EN
         life          <= life_nxt;
`endif
      end
   end

   // Next-state and datapath decisions, evaluated only on a frame tick
   always_comb begin
      state_nxt     = state;
      dir_nxt       = dir;
      fly_dir_nxt   = fly_dir;
      fire_prev_nxt = fire_prev;
      cd_nxt        = cd;
      x_nxt         = MissileX;
      y_nxt         = MissileY;
      active_nxt    = MissileActive;
`ifdef MISSILE_WRAP_EN
      life_nxt      = life;
`endif
      if (frame_tick) begin
         fire_prev_nxt = (keycode == KEY_FIRE);
         case (keycode)
            KEY_W:   dir_nxt = UP;
            KEY_S:   dir_nxt = DOWN;
            KEY_A:   dir_nxt = LEFT;
            KEY_D:   dir_nxt = RIGHT;
            default: dir_nxt = dir;
         endcase
         case (state)
            IDLE: begin
               if (fire_edge && spawn_ok) begin
                  x_nxt       = spawn_x[9:0];
                  y_nxt       = spawn_y[9:0];
                  fly_dir_nxt = dir;
                  active_nxt  = 1'b1;
                  state_nxt   = FLYING;
`ifdef MISSILE_WRAP_EN
                  life_nxt    = '0;
`endif
               end
            end
            FLYING: begin
`ifdef MISSILE_WRAP_EN
               if (life_inc == LT_W'(LIFETIME_FRAMES)) begin
                  active_nxt = 1'b0;
                  cd_nxt     = CD_W'(COOLDOWN_FRAMES);
                  state_nxt  = COOLDOWN;
               end else begin
                  x_nxt    = wrap_x[9:0];
                  y_nxt    = wrap_y[9:0];
                  life_nxt = life_inc;
               end
`else
               if (!step_ok) begin
                  active_nxt = 1'b0;
                  cd_nxt     = CD_W'(COOLDOWN_FRAMES);
                  state_nxt  = COOLDOWN;
               end else begin
                  x_nxt = step_x[9:0];
                  y_nxt = step_y[9:0];
               end
`endif
            end
            COOLDOWN: begin
               if (cd == '0) state_nxt = IDLE;
               else          cd_nxt    = cd - CD_W'(1);
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

`ifdef MISSILE_WRAP_EN
   // In the wrap build the edge test only feeds the wrap path
   logic unused_step_ok;
   assign unused_step_ok = step_ok;
`endif

endmodule
`default_nettype wire

// File: tb/tb_missile_launcher.sv
`default_nettype none
// =============================================================================
//  Module   : tb_missile_launcher
//  Purpose  : Directed self-checking bench for missile_launcher.
//  Revision : 1.0 - initial release
// =============================================================================
module tb_missile_launcher;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       frame_clk = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic [9:0] JetX = 10'd320;
   logic [9:0] JetY = 10'd240;
   logic [9:0] JetS = 10'd80;
   logic [9:0] MissileX, MissileY, MissileS;
   logic       MissileActive;

   int vectors    = 0;
   int miscompares = 0;

   missile_launcher dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .frame_clk     (frame_clk),
      .keycode       (keycode),
      .JetX          (JetX),
      .JetY          (JetY),
      .JetS          (JetS),
      .MissileX      (MissileX),
      .MissileY      (MissileY),
      .MissileS      (MissileS),
      .MissileActive (MissileActive)
   );

   always #5 Clk = ~Clk;

   // One frame strobe; returns at a falling Clk edge after the tick has landed
   task automatic frame(input logic [7:0] key);
      keycode = key;
      @(negedge Clk) frame_clk = 1'b1;
      repeat (4) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_pos(input string tag, input int ex, input int ey, input int ea);
      check({tag, ".x"}, int'(MissileX), ex);
      check({tag, ".y"}, int'(MissileY), ey);
      check({tag, ".act"}, int'(MissileActive), ea);
   endtask

   initial begin
      int y;
      int x;
      // ---------------- reset state ----------------
      repeat (3) @(negedge Clk);
      check_pos("reset", 0, 0, 0);
      check("reset.size", int'(MissileS), 4);
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
`ifdef MISSILE_WRAP_EN
      // ---------------- wrap build: RIGHT launch wraps, then expires ----------------
      frame(8'h07);
      frame(8'h2C);
      check_pos("wrap.launch", 400, 240, 1);
      x = 400;
      for (int k = 1; k <= 59; k++) begin
         frame(8'h00);
         x = x + 8;
         if (x > 639) x = x - 635;
         if (k == 29) check("wrap.pre", int'(MissileX), 632);
         if (k == 30) check("wrap.wrapped", int'(MissileX), 5);
         check_pos("wrap.fly", x, 240, 1);
      end
      frame(8'h00);
      check_pos("wrap.expire", x, 240, 0);
`else
      // ---------------- UP launch, fly to top edge ----------------
      frame(8'h2C);
      check_pos("up.launch", 320, 160, 1);
      y = 160;
      for (int k = 0; k < 19; k++) begin
         frame(8'h2C);
         y = y - 8;
         check_pos("up.fly", 320, y, 1);
      end
      frame(8'h2C);
      check_pos("up.retire", 320, 8, 0);

      // ---------------- held fire across cooldown: no relaunch ----------------
      for (int k = 0; k < 30; k++) begin
         frame(8'h2C);
         check("held.act", int'(MissileActive), 0);
      end
      frame(8'h00);
      frame(8'h2C);
      check_pos("repress.launch", 320, 160, 1);
      for (int k = 0; k < 20; k++) frame(8'h00);
      check_pos("second.retire", 320, 8, 0);

      // ---------------- cooldown boundary: 16 ticks of lockout ----------------
      for (int t = 1; t <= 18; t++) begin
         if (t == 10 || t == 16 || t == 18) frame(8'h2C);
         else                               frame(8'h00);
         if (t == 10) check("cd.t10", int'(MissileActive), 0);
         if (t == 16) check("cd.t16", int'(MissileActive), 0);
      end
      check_pos("cd.t18.launch", 320, 160, 1);
      for (int k = 0; k < 20; k++) frame(8'h00);
      check_pos("third.retire", 320, 8, 0);
      for (int k = 0; k < 17; k++) frame(8'h00);

      // ---------------- out-of-range spawn (RIGHT from x=600) ----------------
      JetX = 10'd600;
      frame(8'h07);
      frame(8'h2C);
      check_pos("oor", 320, 8, 0);
      frame(8'h00);
      check("oor.after", int'(MissileActive), 0);

      // ---------------- LEFT launch, steering keys ignored in flight ----------------
      JetX = 10'd320;
      frame(8'h04);
      frame(8'h2C);
      check_pos("left.launch", 240, 240, 1);
      JetX = 10'd100;  // jet motion after launch must not matter
      JetY = 10'd100;
      frame(8'h1A);
      check_pos("left.w1", 232, 240, 1);
      frame(8'h1A);
      check_pos("left.w2", 224, 240, 1);
      frame(8'h16);    // dir becomes DOWN, flight stays LEFT
      check_pos("left.s", 216, 240, 1);

      // ---------------- asynchronous reset mid-flight ----------------
      @(negedge Clk);
      #2 Reset = 1'b0;
      #1 check_pos("async.rst", 0, 0, 0);
      repeat (3) @(negedge Clk);
      Reset = 1'b1;
      JetX = 10'd320;
      JetY = 10'd240;
      frame(8'h00);
      check("post.rst.idle", int'(MissileActive), 0);
      frame(8'h2C);
      check_pos("post.rst.up", 320, 160, 1);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
